// File: rtl/tmds_rx_decoder_pkg.sv
// tmds_rx_decoder_pkg
// Shared definitions for the TMDS receive channel:
//   - the four TMDS control tokens, also used by the transmit encoder
//   - the alignment FSM state encoding
//   - the decoded-symbol record passed from the symbol decoder to the top
//   - is_token(): true when a 10b symbol is one of the control tokens
package tmds_rx_decoder_pkg;

    localparam int NUM_OFS = 10;  // candidate bit offsets within the 20b window

    localparam logic [9:0] TOK_C00 = 10'h354;
    localparam logic [9:0] TOK_C01 = 10'h0AB;
    localparam logic [9:0] TOK_C10 = 10'h154;
    localparam logic [9:0] TOK_C11 = 10'h2AB;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    typedef struct packed {
        logic       de;    // 1 = video data, 0 = control token
        logic [1:0] ctrl;  // {C1,C0}, meaningful when de = 0
        logic [7:0] data;  // pixel byte, meaningful when de = 1
    } dec_sym_t;

    function automatic logic is_token(input logic [9:0] sym);
        return (sym == TOK_C00) || (sym == TOK_C01) ||
               (sym == TOK_C10) || (sym == TOK_C11);
    endfunction

endpackage

// File: rtl/tmds_sym_decode.sv
// tmds_sym_decode
// Combinational 10b -> {de, ctrl, data} TMDS symbol decoder.
// Ports:
//   sym  in  10  aligned TMDS symbol
//   dec  out     decoded record; data is 0 for control tokens, ctrl is 0 for data
module tmds_sym_decode
    import tmds_rx_decoder_pkg::*;
(
    input  logic [9:0] sym,
    output dec_sym_t   dec
);

    logic [7:0] d;

    always_comb begin
        dec = '0;
        // bit 9 marks an inverted payload; undo it before the XOR/XNOR chain
        d   = sym[9] ? ~sym[7:0] : sym[7:0];
        case (sym)
            TOK_C00: dec.ctrl = 2'b00;
            TOK_C01: dec.ctrl = 2'b01;
            TOK_C10: dec.ctrl = 2'b10;
            TOK_C11: dec.ctrl = 2'b11;
            default: begin
                dec.de      = 1'b1;
                dec.data[0] = d[0];
                // bit 8 selects XOR (1) or XNOR (0) transition coding
                for (int i = 1; i < 8; i++) begin
                    dec.data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
                end
            end
        endcase
    end

endmodule

// File: rtl/tmds_rx_decoder.sv
// tmds_rx_decoder
// One TMDS channel of a DVI/HDMI sink: finds word alignment on control tokens
// in an arbitrarily phased 10b deserializer stream and decodes aligned symbols.
// Ports:
//   sys_clk     in   1   pixel clock, rising edge
//   sys_rst_n   in   1   asynchronous active-low reset
//   raw_word    in  10   deserialized word, bit0 first on the wire
//   raw_vld     in   1   raw_word valid; all state advances only when high
//   dec_data    out  8   decoded pixel byte (dec_de = 1)
//   dec_ctrl    out  2   decoded {C1,C0} (dec_de = 0), held across data
//   dec_de      out  1   1 = data symbol, 0 = control token
//   dec_vld     out  1   decoded outputs valid, only while locked
//   locked      out  1   alignment lock status
//   bit_offset  out  4   alignment offset 0..9
module tmds_rx_decoder
    import tmds_rx_decoder_pkg::*;
#(
    parameter int LOCK_CNT     = 8,
    parameter int LOSS_TIMEOUT = 2048
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [9:0] raw_word,
    input  logic       raw_vld,
    output logic [7:0] dec_data,
    output logic [1:0] dec_ctrl,
    output logic       dec_de,
    output logic       dec_vld,
    output logic       locked,
    output logic [3:0] bit_offset
);

    localparam int RUN_W  = $clog2(LOCK_CNT) + 1;
    localparam int LOSS_W = $clog2(LOSS_TIMEOUT) + 1;

    state_e            state_q, state_d;
    logic [9:0]        prev_q, prev_d;
    logic [3:0]        offset_q, offset_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [LOSS_W-1:0] loss_q, loss_d;
    logic              locked_q, locked_d;
    logic              dec_vld_q, dec_vld_d;
    logic              dec_de_q, dec_de_d;
    logic [1:0]        dec_ctrl_q, dec_ctrl_d;
    logic [7:0]        dec_data_q, dec_data_d;

    // Current word on top of the previous one: symbol k starts k bits into prev.
    logic [19:0]                  win;
    logic [NUM_OFS-1:0][9:0]      sym_arr;
    logic [NUM_OFS-1:0]           tok_hit;
    logic [3:0]                   hit_ofs;
    logic                         sel_tok;
    dec_sym_t                     dec_sym;

    assign win = {raw_word, prev_q};

    for (genvar k = 0; k < NUM_OFS; k++) begin : g_ofs
        assign sym_arr[k] = win[k+9:k];
        assign tok_hit[k] = is_token(sym_arr[k]);
    end

    // Lowest offset wins when several alignments see a token.
    always_comb begin
        hit_ofs = '0;
        for (int k = NUM_OFS - 1; k >= 0; k--) begin
            if (tok_hit[k]) hit_ofs = 4'(k);
        end
    end

    assign sel_tok = tok_hit[offset_q];

    tmds_sym_decode u_sym_decode (
        .sym (sym_arr[offset_q]),
        .dec (dec_sym)
    );

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        offset_d = offset_q;
        run_d    = run_q;
        loss_d   = loss_q;
        if (raw_vld) begin
            prev_d = raw_word;
            case (state_q)
                ST_SEARCH: begin
                    if (|tok_hit) begin
                        offset_d = hit_ofs;
                        run_d    = RUN_W'(1);
                        state_d  = ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (!sel_tok) begin
                        // the failing word is dropped, not rescanned
                        run_d   = '0;
                        state_d = ST_SEARCH;
                    end else if (run_q >= RUN_W'(LOCK_CNT - 1)) begin
                        run_d   = RUN_W'(LOCK_CNT);
                        loss_d  = '0;
                        state_d = ST_LOCKED;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end
                ST_LOCKED: begin
                    // a token always clears the timer, so it can never coincide with timeout
                    if (sel_tok) begin
                        loss_d = '0;
                    end else if (loss_q >= LOSS_W'(LOSS_TIMEOUT - 1)) begin
                        loss_d  = LOSS_W'(LOSS_TIMEOUT);
                        run_d   = '0;
                        state_d = ST_SEARCH;
                    end else begin
                        loss_d = loss_q + LOSS_W'(1);
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    // Using the next state lets the word that completes the lock count be
    // emitted, and suppresses the word that triggers the timeout.
    always_comb begin
        locked_d   = (state_d == ST_LOCKED);
        dec_vld_d  = raw_vld && (state_d == ST_LOCKED);
        dec_de_d   = dec_de_q;
        dec_ctrl_d = dec_ctrl_q;
        dec_data_d = dec_data_q;
        if (dec_vld_d) begin
            dec_de_d   = dec_sym.de;
            dec_data_d = dec_sym.data;
            if (!dec_sym.de) dec_ctrl_d = dec_sym.ctrl;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_SEARCH;
            prev_q     <= '0;
            offset_q   <= '0;
            run_q      <= '0;
            loss_q     <= '0;
            locked_q   <= 1'b0;
            dec_vld_q  <= 1'b0;
            dec_de_q   <= 1'b0;
            dec_ctrl_q <= '0;
            dec_data_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            offset_q   <= offset_d;
            run_q      <= run_d;
            loss_q     <= loss_d;
            locked_q   <= locked_d;
            dec_vld_q  <= dec_vld_d;
            dec_de_q   <= dec_de_d;
            dec_ctrl_q <= dec_ctrl_d;
            dec_data_q <= dec_data_d;
        end
    end

    assign dec_data   = dec_data_q;
    assign dec_ctrl   = dec_ctrl_q;
    assign dec_de     = dec_de_q;
    assign dec_vld    = dec_vld_q;
    assign locked     = locked_q;
    assign bit_offset = offset_q;

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// tb_tmds_rx_decoder
// Directed bench for tmds_rx_decoder. Inputs change on the falling edge and
// outputs are checked on the falling edge, half a cycle after the rising edge
// that consumed the last word.
module tb_tmds_rx_decoder;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic [9:0] raw_word  = '0;
    logic       raw_vld   = 1'b0;
    logic [7:0] dec_data;
    logic [1:0] dec_ctrl;
    logic       dec_de;
    logic       dec_vld;
    logic       locked;
    logic [3:0] bit_offset;

    int n_assert = 0;
    int n_fail   = 0;

    logic [9:0] last_sym = '0;  // previous symbol on the modelled wire

    tmds_rx_decoder dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .raw_word   (raw_word),
        .raw_vld    (raw_vld),
        .dec_data   (dec_data),
        .dec_ctrl   (dec_ctrl),
        .dec_de     (dec_de),
        .dec_vld    (dec_vld),
        .locked     (locked),
        .bit_offset (bit_offset)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one word for one rising edge, return on the following falling edge.
    task automatic send(input logic [9:0] w, input logic v);
        raw_word = w;
        raw_vld  = v;
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    // Deserializer phase model: symbols back to back on the wire, word
    // boundary sitting ofs bits into each symbol.
    function automatic logic [9:0] wire_word(input logic [9:0] sym, input logic [9:0] prv, input int ofs);
        logic [19:0] t;
        t = {sym, prv};
        return t[19-ofs -: 10];
    endfunction

    task automatic send_rot(input logic [9:0] sym, input int ofs);
        send(wire_word(sym, last_sym, ofs), 1'b1);
        last_sym = sym;
    endtask

    // Asynchronous assert (checked before any clock edge), release on a falling edge.
    task automatic do_reset(input string tag);
        raw_vld   = 1'b0;
        raw_word  = '0;
        last_sym  = '0;
        sys_rst_n = 1'b0;
        #1;
        chk({tag, "_locked"},     locked,     0);
        chk({tag, "_dec_vld"},    dec_vld,    0);
        chk({tag, "_bit_offset"}, bit_offset, 0);
        chk({tag, "_dec_de"},     dec_de,     0);
        chk({tag, "_dec_ctrl"},   dec_ctrl,   0);
        chk({tag, "_dec_data"},   dec_data,   0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        @(negedge sys_clk);

        // 1: lock on 10'h354 at offset 0
        do_reset("rst1");
        repeat (8) send(10'h354, 1'b1);
        chk("t1_locked_pre", locked, 0);
        chk("t1_vld_pre", dec_vld, 0);
        send(10'h354, 1'b1);
        chk("t1_locked", locked, 1);
        chk("t1_vld", dec_vld, 1);
        chk("t1_offset", bit_offset, 0);
        chk("t1_de", dec_de, 0);
        chk("t1_ctrl", dec_ctrl, 2'b00);
        repeat (3) send(10'h354, 1'b1);

        // 3: data symbols, two clocks after input
        send(10'h100, 1'b1);
        send(10'h2FF, 1'b1);
        chk("t3_de_100", dec_de, 1);
        chk("t3_data_100", dec_data, 8'h00);
        send(10'h101, 1'b1);
        chk("t3_data_2ff", dec_data, 8'hFE);
        send(10'h001, 1'b1);
        chk("t3_data_101", dec_data, 8'h03);
        send(10'h354, 1'b1);
        chk("t3_data_001", dec_data, 8'hFD);
        chk("t3_de_001", dec_de, 1);

        // 4: CONFIRM broken by a data word -> restart from SEARCH
        do_reset("rst4");
        repeat (5) send(10'h354, 1'b1);
        send(10'h100, 1'b1);
        for (int i = 0; i < 7; i++) begin
            send(10'h354, 1'b1);
            chk("t4_vld_low", dec_vld, 0);
        end
        chk("t4_locked_low", locked, 0);
        send(10'h354, 1'b1);
        chk("t4_locked_pre", locked, 0);
        send(10'h354, 1'b1);
        chk("t4_relock", locked, 1);

        // 5: 2048 data words with no token drop lock
        repeat (2048) send(10'h100, 1'b1);
        chk("t5_locked_2047", locked, 1);
        chk("t5_vld_2047", dec_vld, 1);
        chk("t5_de_2047", dec_de, 1);
        send(10'h100, 1'b1);
        chk("t5_locked_loss", locked, 0);
        chk("t5_vld_loss", dec_vld, 0);
        chk("t5_offset_hold", bit_offset, 0);
        repeat (8) send(10'h354, 1'b1);
        chk("t5_relock_pre", locked, 0);
        send(10'h354, 1'b1);
        chk("t5_relock", locked, 1);

        // 2: stream rotated by 3 bits
        do_reset("rst2");
        send_rot(10'h354, 3);
        send_rot(10'h354, 3);
        chk("t2_offset_confirm", bit_offset, 3);
        repeat (6) send_rot(10'h354, 3);
        chk("t2_locked_pre", locked, 0);
        send_rot(10'h354, 3);
        chk("t2_locked", locked, 1);
        chk("t2_offset", bit_offset, 3);
        send_rot(10'h0AB, 3);
        send_rot(10'h100, 3);
        chk("t2_ctrl_01", dec_ctrl, 2'b01);
        chk("t2_de_tok", dec_de, 0);
        send_rot(10'h354, 3);
        chk("t2_de_data", dec_de, 1);
        chk("t2_ctrl_hold", dec_ctrl, 2'b01);
        chk("t2_data", dec_data, 8'h00);

        // 6: raw_vld toggling during lock-up
        do_reset("rst6");
        for (int i = 0; i < 8; i++) begin
            send(10'h354, 1'b1);
            send(10'h3FF, 1'b0);
        end
        chk("t6_locked_pre", locked, 0);
        send(10'h354, 1'b1);
        chk("t6_locked", locked, 1);
        chk("t6_vld", dec_vld, 1);
        send(10'h3FF, 1'b0);
        chk("t6_vld_gap", dec_vld, 0);
        chk("t6_locked_gap", locked, 1);

        // 6: reset pulse while in CONFIRM at offset 3
        do_reset("rst6b");
        repeat (3) send_rot(10'h354, 3);
        chk("t6_confirm_offset", bit_offset, 3);
        chk("t6_confirm_locked", locked, 0);
        do_reset("rst6c");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
